// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions, decoder states
// and the immediate sign-extension helper used by the PC-update logic.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_BEQ   = 4'd10;
    localparam logic [3:0] OP_BNE   = 4'd11;
    localparam logic [3:0] OP_JUMP  = 4'd12;
    localparam logic [3:0] OP_AES   = 4'd13;
    localparam logic [3:0] OP_I2C   = 4'd14;
    localparam logic [3:0] OP_MUL   = 4'd15;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RS_MSB     = 11;
    localparam int RS_LSB     = 9;
    localparam int RT_MSB     = 8;
    localparam int RT_LSB     = 6;
    localparam int RD_MSB     = 5;
    localparam int RD_LSB     = 3;
    localparam int IMM_MSB    = 5;
    localparam int IMM_LSB    = 0;
    localparam int JT_MSB     = 11;
    localparam int JT_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } decState_t;

    function automatic logic signed [PC_W-1:0] signExtendImm(input logic [5:0] immVal);
        return signed'({{(PC_W-6){immVal[5]}}, immVal});
    endfunction

endpackage

// File: rtl/instruction_decoder_next_pc.sv
// Combinational PC update: jump beats branch beats sequential, all modulo 2^16.
module next_pc
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [11:0]     jumpTarget,
    input  logic [5:0]      imm,
    input  logic            jumpExecute,
    input  logic            branchTaken,
    output logic [PC_W-1:0] nextPc
);

    logic signed [PC_W-1:0] immExt;

    assign immExt = signExtendImm(imm);

    always_comb begin
        nextPc = pc + 16'd1;
        if (jumpExecute) begin
            nextPc = {pc[PC_W-1:12], jumpTarget};
        end else if (branchTaken) begin
            nextPc = pc + 16'd1 + $unsigned(immExt);
        end
    end

endmodule

// File: rtl/instruction_decoder.sv
// Fetch-and-decode stage feeding the control unit; holds decoded fields until retire.
// Optional fetch timeout enabled by defining IDECODE_FETCH_TIMEOUT_EN.
module instruction_decoder
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readInstruction,
    input  logic        writeBackComplete,
    input  logic        jumpExecute,
    input  logic        branchTaken,
    input  logic [15:0] imemData,
    input  logic        imemValid,
    output logic        imemRead,
    output logic [15:0] imemAddr,
    output logic [3:0]  opcode,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic [2:0]  rd,
    output logic [5:0]  imm,
    output logic [11:0] jumpTarget,
    output logic [15:0] pc,
    output logic        decodeComplete,
    output logic        fetchError
);

    if (FETCH_TIMEOUT < 1) begin : gTimeoutCheck
        $error("FETCH_TIMEOUT must be at least 1");
    end

    decState_t          state;
    logic [INSTR_W-1:0] instrReg;
    logic               wbcPrev;
    logic               wbcEdge;
    logic               timeoutHit;
    logic [PC_W-1:0]    pcNext;

    assign wbcEdge = writeBackComplete & ~wbcPrev;

    next_pc uNextPc (
        .pc          (pc),
        .jumpTarget  (jumpTarget),
        .imm         (imm),
        .jumpExecute (jumpExecute),
        .branchTaken (branchTaken),
        .nextPc      (pcNext)
    );

`ifdef IDECODE_FETCH_TIMEOUT_EN
    logic [15:0] fetchCnt;
    logic        fetchErrorReg;

    // The counter restarts every time FETCH is entered, so a retry gets a full window.
    assign timeoutHit = (state == FETCH) && !imemValid && (fetchCnt == 16'(FETCH_TIMEOUT - 1));
    assign fetchError = fetchErrorReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchCnt      <= '0;
            fetchErrorReg <= 1'b0;
        end else if (state != FETCH || imemValid) begin
            fetchCnt <= '0;
        end else if (timeoutHit) begin
            fetchCnt      <= '0;
            fetchErrorReg <= 1'b1;
        end else begin
            fetchCnt <= fetchCnt + 16'd1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign fetchError = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imemAddr       <= RESET_PC;
            imemRead       <= 1'b0;
            instrReg       <= '0;
            opcode         <= '0;
            rs             <= '0;
            rt             <= '0;
            rd             <= '0;
            imm            <= '0;
            jumpTarget     <= '0;
            decodeComplete <= 1'b0;
            wbcPrev        <= 1'b0;
        end else begin
            wbcPrev <= writeBackComplete;
            unique case (state)
                IDLE: begin
                    if (readInstruction) begin
                        state    <= FETCH;
                        imemRead <= 1'b1;
                        imemAddr <= pc;
                    end
                end
                FETCH: begin
                    if (imemValid) begin
                        instrReg <= imemData;
                        imemRead <= 1'b0;
                        state    <= DECODE;
                    end else if (timeoutHit) begin
                        imemRead <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DECODE: begin
                    opcode         <= instrReg[OPCODE_MSB:OPCODE_LSB];
                    rs             <= instrReg[RS_MSB:RS_LSB];
                    rt             <= instrReg[RT_MSB:RT_LSB];
                    rd             <= instrReg[RD_MSB:RD_LSB];
                    imm            <= instrReg[IMM_MSB:IMM_LSB];
                    jumpTarget     <= instrReg[JT_MSB:JT_LSB];
                    decodeComplete <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    // Only a retire edge seen here moves the PC; edges elsewhere are dropped.
                    if (wbcEdge) begin
                        pc             <= pcNext;
                        imemAddr       <= pcNext;
                        decodeComplete <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
